// File: rtl/fetch_unit.sv
// Instruction sequencer feeding the bitty core; optional local branches under `BRANCH_EN`.
// Latency: start -> run in 2 cycles; done -> next run in 3 cycles.
// Backpressure: one instruction in flight and no new issue until the core returns done.
module fetch_unit #(
  parameter int          ADDR_W     = 8,
  parameter int          DEPTH      = 256,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              done,
  input  logic [15:0]       d_out,
  output logic              run,
  output logic [15:0]       d_instr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_HALTED
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       mem [DEPTH];
  logic              idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_HALTED);
  assign busy      = (state == S_FETCH) || (state == S_ISSUE) ||
                     (state == S_WAIT)  || (state == S_NEXT);
  assign halted    = (state == S_HALTED);

  // Program memory has no reset; writes only land while the sequencer is parked.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && idle_like)
      mem[prog_addr] <= prog_data;
  end

`ifdef BRANCH_EN
  logic [15:0] last_res;
  logic        is_branch;
  logic        take;

  assign is_branch = (d_instr[1:0] == 2'b10);

  always_comb begin
    take = 1'b0;
    case (d_instr[3:2])
      2'b00:   take = (last_res == 16'd0);
      2'b01:   take = (last_res == 16'd1);
      2'b10:   take = (last_res == 16'd2);
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_res <= 16'd0;
    else if (state == S_WAIT && done)
      last_res <= d_out;
  end
`else
  logic unused_d_out;
  assign unused_d_out = ^d_out;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      d_instr <= 16'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_FETCH)
        d_instr <= mem[pc];
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    run       = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        // The halt word is consumed here and never reaches the core.
        if (d_instr == HALT_INSTR)
          state_nxt = S_HALTED;
`ifdef BRANCH_EN
        else if (is_branch) begin
          if (take) begin
            pc_nxt    = d_instr[ADDR_W+3:4];
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_NEXT;
          end
        end
`endif
        else begin
          run       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done)
          state_nxt = S_NEXT;
      end
      S_NEXT: begin
        pc_nxt    = pc + 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected run pulses, a negedge monitor checks them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, prog_we, done;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data, d_out;
  logic        run, busy, halted;
  logic [15:0] d_instr;
  logic [7:0]  pc;

  fetch_unit #(.ADDR_W(8), .DEPTH(256), .HALT_INSTR(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .done(done), .d_out(d_out),
    .run(run), .d_instr(d_instr), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pcv;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   ack_lat = 3, ack_cnt = -1, busy_drops = 0;
  bit   hold_done = 1'b0, chk_busy = 1'b0;

`ifdef BRANCH_EN
  localparam logic [15:0] W1 = 16'h0003;
`else
  localparam logic [15:0] W1 = 16'h0002;
`endif

  // Monitor: every run pulse must match the head of the expected queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_busy && busy !== 1'b1) busy_drops++;
      if (run === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_run: got instr %h pc %0d cycle %0d, required no run", d_instr, pc, cyc);
        end else begin
          e = exp_q.pop_front();
          if (d_instr !== e.instr || pc !== e.pcv || (e.at >= 0 && cyc != e.at)) begin
            miscompares++;
            $display("FAIL run_seq: got instr %h pc %0d cycle %0d, required instr %h pc %0d cycle %0d",
                     d_instr, pc, cyc, e.instr, e.pcv, e.at);
          end
        end
        if (!hold_done) ack_cnt = ack_lat - 1;
      end
    end
  end

  // Core model: done pulses ack_lat cycles after each run, or held high.
  initial begin : core_model
    forever begin
      @(posedge clk);
      #1;
      if (hold_done) done = 1'b1;
      else if (ack_cnt == 0) begin
        done    = 1'b1;
        ack_cnt = -1;
      end else begin
        done = 1'b0;
        if (ack_cnt > 0) ack_cnt--;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [7:0] pcv, input int at);
    exp_t e;
    e.instr = instr;
    e.pcv   = pcv;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d runs still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, halted, 1);
  endtask

  initial begin : stim
    int sc;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 8'd0;
    prog_data = 16'd0; d_out = 16'd0; done = 1'b0;
    tick(3);
    check("rst_run", run, 0);
    check("rst_d_instr", d_instr, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Two instructions then halt; the halt word never produces run.
    load(8'd0, 16'h0001); load(8'd1, W1); load(8'd2, 16'hFFFF);
    ack_lat = 3;
    sc = cyc;
    push(16'h0001, 8'd0, sc + 2);
    push(W1, 8'd1, sc + 8);
    pulse_start();
    wait_drain("seq_drain", 40);
    wait_halted("seq_halted", 20);
    check("seq_halt_busy", busy, 0);
    check("seq_halt_pc", pc, 2);

    // Start-to-run and done-to-run latency.
    load(8'd0, 16'h0021); load(8'd1, 16'h0031); load(8'd2, 16'hFFFF);
    ack_lat = 4;
    sc = cyc;
    push(16'h0021, 8'd0, sc + 2);
    push(16'h0031, 8'd1, sc + 9);
    pulse_start();
    wait_drain("lat_drain", 40);
    wait_halted("lat_halted", 20);

    // Write and start while busy must be ignored.
    load(8'd0, 16'h0011); load(8'd1, 16'hFFFF);
    ack_lat = 6;
    sc = cyc;
    push(16'h0011, 8'd0, sc + 2);
    pulse_start();
    tick(2);
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h1234; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    check("busy_we_busy", busy, 1);
    wait_drain("busy_we_drain", 40);
    wait_halted("busy_we_halted", 20);
    sc = cyc;
    push(16'h0011, 8'd0, sc + 2);
    pulse_start();
    wait_drain("rerun_drain", 40);
    wait_halted("rerun_halted", 20);

    // Write and start on the same edge: the fetch sees the new word.
    sc = cyc;
    push(16'h0041, 8'd0, sc + 2);
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 16'h0041; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_drain("we_start_drain", 40);
    wait_halted("we_start_halted", 20);

    // Reset while waiting for done; the late done is ignored.
    ack_lat = 6;
    sc = cyc;
    push(16'h0041, 8'd0, sc + 2);
    pulse_start();
    tick(2);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_halted", halted, 0);
    check("midrst_pc", pc, 0);
    check("midrst_d_instr", d_instr, 0);
    check("midrst_run", run, 0);
    reset = 1'b0;
    tick(8);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_halted", halted, 0);
    wait_drain("midrst_queue", 1);

    // Full memory of non-halt words with done held high: pc wraps.
    for (int i = 0; i < 256; i++) load(i[7:0], {i[7:0], 8'h01});
    hold_done = 1'b1;
    tick(2);
    sc = cyc;
    for (int k = 0; k <= 256; k++) push({k[7:0], 8'h01}, k[7:0], sc + 2 + 4 * k);
    pulse_start();
    chk_busy = 1'b1;
    wait_drain("wrap_drain", 1100);
    chk_busy = 1'b0;
    hold_done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_busy_held", busy_drops, 0);
    tick(2);

    // Format-10 word 16'h0056: target 5, cond last_res==1.
    load(8'd0, 16'h0101); load(8'd1, 16'h0111); load(8'd2, 16'h0056);
    load(8'd3, 16'h0131); load(8'd4, 16'hFFFF); load(8'd5, 16'h0151); load(8'd6, 16'hFFFF);
    ack_lat = 3;
    d_out = 16'd1;
    sc = cyc;
    push(16'h0101, 8'd0, sc + 2);
    push(16'h0111, 8'd1, sc + 8);
`ifdef BRANCH_EN
    push(16'h0151, 8'd5, sc + 16);
    pulse_start();
    wait_drain("br_taken_drain", 60);
    wait_halted("br_taken_halted", 20);
    check("br_taken_pc", pc, 6);
    d_out = 16'd0;
    sc = cyc;
    push(16'h0101, 8'd0, sc + 2);
    push(16'h0111, 8'd1, sc + 8);
    push(16'h0131, 8'd3, sc + 17);
    pulse_start();
    wait_drain("br_not_taken_drain", 60);
    wait_halted("br_not_taken_halted", 20);
    check("br_not_taken_pc", pc, 4);
`else
    push(16'h0056, 8'd2, sc + 14);
    push(16'h0131, 8'd3, sc + 20);
    pulse_start();
    wait_drain("fmt10_issue_drain", 60);
    wait_halted("fmt10_halted", 20);
    check("fmt10_halt_pc", pc, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
